// File: rtl/lsu_bus_master_pkg.sv
// Shared encodings for the LSU bus master and its data alignment helper.
package lsu_bus_master_pkg;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 32;

  localparam logic [1:0] REQ_READ  = 2'b01;
  localparam logic [1:0] REQ_WRITE = 2'b10;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_D = 2'b11;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  // Illegal encodings (funct3=111, unsigned store) are folded into misalignment.
  function automatic logic op_misaligned(input logic store, input logic [2:0] funct3,
                                         input logic [2:0] addr_lo);
    logic bad_type;
    logic bad_addr;
    bad_type = (funct3 == 3'b111) || (store && funct3[2]);
    case (funct3[1:0])
      SIZE_B:  bad_addr = 1'b0;
      SIZE_H:  bad_addr = addr_lo[0];
      SIZE_W:  bad_addr = (addr_lo[1:0] != 2'b00);
      default: bad_addr = (addr_lo != 3'b000);
    endcase
    return bad_type || bad_addr;
  endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Byte-lane alignment: store data placement and load extraction/extension.
module lsu_data_align
  import lsu_bus_master_pkg::*;
(
  input  logic [2:0]        addr_lo,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] wdata_lane,
  output logic [DATA_W-1:0] rdata_ext
);

  logic [5:0]        shamt;
  logic [DATA_W-1:0] size_mask;
  logic [DATA_W-1:0] rsh;

  assign shamt = {addr_lo, 3'b000};

  // Mask store data to the access size, shift into lanes; shift load data down and extend.
  always_comb begin
    case (funct3[1:0])
      SIZE_B:  size_mask = 64'h0000_0000_0000_00FF;
      SIZE_H:  size_mask = 64'h0000_0000_0000_FFFF;
      SIZE_W:  size_mask = 64'h0000_0000_FFFF_FFFF;
      default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    wdata_lane = (wdata & size_mask) << shamt;
    rsh        = rdata >> shamt;
    case (funct3)
      3'b000:  rdata_ext = {{56{rsh[7]}},  rsh[7:0]};
      3'b001:  rdata_ext = {{48{rsh[15]}}, rsh[15:0]};
      3'b010:  rdata_ext = {{32{rsh[31]}}, rsh[31:0]};
      3'b100:  rdata_ext = {56'd0, rsh[7:0]};
      3'b101:  rdata_ext = {48'd0, rsh[15:0]};
      3'b110:  rdata_ext = {32'd0, rsh[31:0]};
      default: rdata_ext = rsh;
    endcase
  end

endmodule

// File: rtl/lsu_bus_master.sv
// LSU initiator on the simple memory-request bus: one load/store per transaction.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for a memory-stage op; misaligned ops skip the bus
// ST_REQ  | bus_valid held with stable fields until bus_ready/timeout
// ST_DONE | one-cycle lsu_done pulse with rdata/fault/misalign valid
module lsu_bus_master
  import lsu_bus_master_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lsu_valid,
  input  logic              lsu_store,
  input  logic [2:0]        lsu_funct3,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  output logic              lsu_stall,
  output logic              lsu_done,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              lsu_misalign,
  output logic              lsu_fault,
  output logic              bus_valid,
  output logic [1:0]        bus_req,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [1:0]        bus_size,
  output logic [DATA_W-1:0] bus_data_write,
  input  logic              bus_ready,
  input  logic [DATA_W-1:0] bus_data_read,
  input  logic [1:0]        bus_resp
);

  // Watchdog runs down from TIMEOUT-1; a stall seen at zero is the TIMEOUT-th.
  localparam logic [CNT_W-1:0] CNT_LOAD = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  lsu_state_e        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              bus_valid_nxt;
  logic [1:0]        bus_req_nxt;
  logic [ADDR_W-1:0] bus_addr_nxt;
  logic [1:0]        bus_size_nxt;
  logic [DATA_W-1:0] bus_data_write_nxt;
  logic [DATA_W-1:0] lsu_rdata_nxt;
  logic              lsu_misalign_nxt;
  logic              lsu_fault_nxt;
  logic [DATA_W-1:0] wdata_lane;
  logic [DATA_W-1:0] rdata_ext;

  // Op fields are held stable by the pipeline while stalled, so they drive alignment in REQ too.
  lsu_data_align u_align (
    .addr_lo    (lsu_addr[2:0]),
    .funct3     (lsu_funct3),
    .wdata      (lsu_wdata),
    .rdata      (bus_data_read),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext)
  );

  assign lsu_done  = (state == ST_DONE);
  assign lsu_stall = lsu_valid & (state != ST_DONE);

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      bus_valid      <= 1'b0;
      bus_req        <= 2'b00;
      bus_addr       <= '0;
      bus_size       <= 2'b00;
      bus_data_write <= '0;
      lsu_rdata      <= '0;
      lsu_misalign   <= 1'b0;
      lsu_fault      <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      bus_valid      <= bus_valid_nxt;
      bus_req        <= bus_req_nxt;
      bus_addr       <= bus_addr_nxt;
      bus_size       <= bus_size_nxt;
      bus_data_write <= bus_data_write_nxt;
      lsu_rdata      <= lsu_rdata_nxt;
      lsu_misalign   <= lsu_misalign_nxt;
      lsu_fault      <= lsu_fault_nxt;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_nxt          = state;
    cnt_nxt            = cnt;
    bus_valid_nxt      = bus_valid;
    bus_req_nxt        = bus_req;
    bus_addr_nxt       = bus_addr;
    bus_size_nxt       = bus_size;
    bus_data_write_nxt = bus_data_write;
    lsu_rdata_nxt      = lsu_rdata;
    lsu_misalign_nxt   = lsu_misalign;
    lsu_fault_nxt      = lsu_fault;
    case (state)
      ST_IDLE: begin
        if (lsu_valid) begin
          if (op_misaligned(lsu_store, lsu_funct3, lsu_addr[2:0])) begin
            lsu_misalign_nxt = 1'b1;
            state_nxt        = ST_DONE;
          end else begin
            bus_valid_nxt      = 1'b1;
            bus_req_nxt        = lsu_store ? REQ_WRITE : REQ_READ;
            bus_addr_nxt       = lsu_addr;
            bus_size_nxt       = lsu_funct3[1:0];
            bus_data_write_nxt = lsu_store ? wdata_lane : '0;
            cnt_nxt            = CNT_LOAD;
            state_nxt          = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (bus_ready) begin
          bus_valid_nxt = 1'b0;
          lsu_rdata_nxt = lsu_store ? '0 : rdata_ext;
          lsu_fault_nxt = (bus_resp != RESP_OKAY);
          state_nxt     = ST_DONE;
        end else if (TIMEOUT != 0) begin
          if (cnt == '0) begin
            bus_valid_nxt = 1'b0;
            lsu_rdata_nxt = '0;
            lsu_fault_nxt = 1'b1;
            state_nxt     = ST_DONE;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
      end
      ST_DONE: begin
        lsu_rdata_nxt    = '0;
        lsu_misalign_nxt = 1'b0;
        lsu_fault_nxt    = 1'b0;
        state_nxt        = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Self-checking bench for lsu_bus_master: directed table, corner sequences, random ops.
module tb_lsu_bus_master;
  import lsu_bus_master_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_valid, lsu_store;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr;
  logic [63:0] lsu_wdata;
  logic        lsu_stall, lsu_done, lsu_misalign, lsu_fault;
  logic [63:0] lsu_rdata;
  logic        bus_valid;
  logic [1:0]  bus_req, bus_size;
  logic [31:0] bus_addr;
  logic [63:0] bus_data_write;
  logic        bus_ready;
  logic [63:0] bus_data_read;
  logic [1:0]  bus_resp;

  lsu_bus_master #(.TIMEOUT(TO), .CNT_W(9)) dut (
    .clk(clk), .rst(rst),
    .lsu_valid(lsu_valid), .lsu_store(lsu_store), .lsu_funct3(lsu_funct3),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_stall(lsu_stall), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
    .lsu_misalign(lsu_misalign), .lsu_fault(lsu_fault),
    .bus_valid(bus_valid), .bus_req(bus_req), .bus_addr(bus_addr),
    .bus_size(bus_size), .bus_data_write(bus_data_write),
    .bus_ready(bus_ready), .bus_data_read(bus_data_read), .bus_resp(bus_resp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          done_cyc;
    int          vcnt;
    logic        mis, fault, stable, stall_ok;
    logic [63:0] rdata, bdw;
    logic [31:0] baddr;
    logic [1:0]  bsize, breq;
  } obs_t;

  typedef struct {
    string     name;
    bit        st;
    bit [2:0]  f3;
    bit [31:0] addr;
    bit [63:0] wd, rd;
    bit [1:0]  resp;
    int        delay;
    bit        e_mis, e_fault;
    bit [63:0] e_rdata, e_bdw;
    int        e_vcnt;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: byte-by-byte view of lanes, sizes and extension.
  function automatic bit m_mis(input bit st, input bit [2:0] f3, input bit [31:0] a);
    int sz;
    sz = 1 << f3[1:0];
    if (f3 == 3'b111 || (st && f3[2])) return 1'b1;
    return (int'(a[2:0]) % sz) != 0;
  endfunction

  function automatic bit [63:0] m_wlane(input bit [2:0] f3, input bit [31:0] a, input bit [63:0] wd);
    bit [63:0] r;
    int sz, off;
    r = '0;
    sz = 1 << f3[1:0];
    off = int'(a[2:0]);
    for (int i = 0; i < sz; i++) r[8*(off+i) +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  function automatic bit [63:0] m_load(input bit [2:0] f3, input bit [31:0] a, input bit [63:0] rd);
    bit [63:0] r;
    int sz, off;
    r = '0;
    sz = 1 << f3[1:0];
    off = int'(a[2:0]);
    for (int i = 0; i < sz; i++) r[8*i +: 8] = rd[8*(off+i) +: 8];
    if (!f3[2] && sz < 8 && r[8*sz-1])
      for (int j = sz; j < 8; j++) r[8*j +: 8] = 8'hFF;
    return r;
  endfunction

  // Drive one op and play the responder; ready comes in valid cycle number 'delay'.
  task automatic run_op(input bit gap, input bit st, input bit [2:0] f3, input bit [31:0] addr,
                        input bit [63:0] wd, input bit [63:0] rd, input bit [1:0] resp,
                        input int delay, output obs_t o);
    int cyc;
    bit done_seen;
    o = '{default: 0};
    o.stable = 1'b1;
    o.stall_ok = 1'b1;
    if (gap) begin
      @(posedge clk); #1;
    end
    lsu_valid = 1'b1; lsu_store = st; lsu_funct3 = f3; lsu_addr = addr; lsu_wdata = wd;
    bus_ready = 1'b0;
    cyc = 0;
    done_seen = 1'b0;
    @(negedge clk);
    if (gap && !lsu_stall) o.stall_ok = 1'b0;
    while (!done_seen && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      bus_ready = 1'b0;
      bus_data_read = {$urandom, $urandom};
      bus_resp = 2'($urandom);
      if (lsu_done) begin
        done_seen = 1'b1;
        o.done_cyc = cyc;
        o.mis = lsu_misalign; o.fault = lsu_fault; o.rdata = lsu_rdata;
        if (lsu_stall) o.stall_ok = 1'b0;
        lsu_valid = 1'b0;
      end else begin
        if (bus_valid) begin
          if (o.vcnt == 0) begin
            o.baddr = bus_addr; o.bsize = bus_size; o.breq = bus_req; o.bdw = bus_data_write;
          end else if (bus_addr !== o.baddr || bus_size !== o.bsize || bus_req !== o.breq ||
                       bus_data_write !== o.bdw) begin
            o.stable = 1'b0;
          end
          if (o.vcnt == delay) begin
            bus_ready = 1'b1; bus_data_read = rd; bus_resp = resp;
          end
          o.vcnt++;
        end
        @(negedge clk);
        if (!lsu_stall) o.stall_ok = 1'b0;
      end
    end
    if (!done_seen) begin
      o.done_cyc = -1;
      lsu_valid = 1'b0;
    end
    bus_ready = 1'b0;
  endtask

  task automatic check_op(input string tag, input obs_t o, input bit gap, input bit st,
                          input bit [2:0] f3, input bit [31:0] addr, input bit e_mis,
                          input bit e_fault, input bit chk_rd, input bit [63:0] e_rdata,
                          input bit [63:0] e_bdw, input int e_vcnt);
    int e_done;
    e_done = (e_mis ? 1 : e_vcnt + 1) + (gap ? 0 : 1);
    chk({tag, " done_cycle"}, o.done_cyc, e_done);
    chk({tag, " valid_cycles"}, o.vcnt, e_vcnt);
    chk({tag, " misalign"}, o.mis, e_mis);
    chk({tag, " fault"}, o.fault, e_fault);
    chk({tag, " stall"}, o.stall_ok, 1'b1);
    if (chk_rd) chk({tag, " rdata"}, o.rdata, e_rdata);
    if (!e_mis) begin
      chk({tag, " bus_addr"}, o.baddr, addr);
      chk({tag, " bus_size"}, o.bsize, f3[1:0]);
      chk({tag, " bus_req"}, o.breq, st ? REQ_WRITE : REQ_READ);
      chk({tag, " fields_stable"}, o.stable, 1'b1);
      if (st) chk({tag, " bus_data_write"}, o.bdw, e_bdw);
    end
  endtask

  initial begin
    obs_t o;
    //         name            st f3      addr           wd                      rd                      rsp dly mis flt rdata                   bdw                     vcnt
    vt[0]  = '{"ld_mtime",     0, 3'b011, 32'h0200_BFF8, 64'h0,                  64'h1234,               0, 0,  0, 0, 64'h1234,               64'h0,                  1};
    vt[1]  = '{"sb_lane5",     1, 3'b000, 32'h8000_0005, 64'hAB,                 64'h0,                  0, 0,  0, 0, 64'h0,                  64'h0000_AB00_0000_0000, 1};
    vt[2]  = '{"lb_sext",      0, 3'b000, 32'h8000_0003, 64'h0,                  64'h0000_0000_8000_0000, 0, 0,  0, 0, 64'hFFFF_FFFF_FFFF_FF80, 64'h0,                  1};
    vt[3]  = '{"lbu_zext",     0, 3'b100, 32'h8000_0003, 64'h0,                  64'h0000_0000_8000_0000, 0, 0,  0, 0, 64'h80,                 64'h0,                  1};
    vt[4]  = '{"lw_misalign",  0, 3'b010, 32'h8000_0002, 64'h0,                  64'h0,                  0, 0,  1, 0, 64'h0,                  64'h0,                  0};
    vt[5]  = '{"ld_timeout",   0, 3'b011, 32'h8000_0000, 64'h0,                  64'h5555,               0, 99, 0, 1, 64'h0,                  64'h0,                  4};
    vt[6]  = '{"lw_resp_err",  0, 3'b010, 32'h8000_0004, 64'h0,                  64'h0,                  1, 0,  0, 1, 64'h0,                  64'h0,                  1};
    vt[7]  = '{"ld_ready_lim", 0, 3'b011, 32'h8000_0010, 64'h0,                  64'hDEAD_BEEF_0123_4567, 0, 3,  0, 0, 64'hDEAD_BEEF_0123_4567, 64'h0,                  4};
    vt[8]  = '{"sd_full",      1, 3'b011, 32'h8000_0008, 64'h0011_2233_4455_6677, 64'h0,                  0, 1,  0, 0, 64'h0,                  64'h0011_2233_4455_6677, 2};
    vt[9]  = '{"sh_lane6",     1, 3'b001, 32'h8000_0006, 64'h1234_5678,          64'h0,                  0, 0,  0, 0, 64'h0,                  64'h5678_0000_0000_0000, 1};
    vt[10] = '{"lh_sext",      0, 3'b001, 32'h8000_0002, 64'h0,                  64'h0000_0000_9ABC_0000, 0, 2,  0, 0, 64'hFFFF_FFFF_FFFF_9ABC, 64'h0,                  3};
    vt[11] = '{"lwu_zext",     0, 3'b110, 32'h8000_0004, 64'h0,                  64'h8765_4321_0000_0000, 0, 0,  0, 0, 64'h0000_0000_8765_4321, 64'h0,                  1};
    vt[12] = '{"lw_sext",      0, 3'b010, 32'h8000_0004, 64'h0,                  64'h8765_4321_0000_0000, 0, 0,  0, 0, 64'hFFFF_FFFF_8765_4321, 64'h0,                  1};
    vt[13] = '{"f3_111",       0, 3'b111, 32'h8000_0000, 64'h0,                  64'h0,                  0, 0,  1, 0, 64'h0,                  64'h0,                  0};
    vt[14] = '{"store_bu",     1, 3'b100, 32'h8000_0000, 64'h0,                  64'h0,                  0, 0,  1, 0, 64'h0,                  64'h0,                  0};
    vt[15] = '{"sw_lane4",     1, 3'b010, 32'h8000_0004, 64'hFFFF_FFFF_CAFE_F00D, 64'h0,                  0, 0,  0, 0, 64'h0,                  64'hCAFE_F00D_0000_0000, 1};

    rst = 1'b1; lsu_valid = 1'b0; lsu_store = 1'b0; lsu_funct3 = 3'b000; lsu_addr = '0;
    lsu_wdata = '0; bus_ready = 1'b0; bus_data_read = '0; bus_resp = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset bus_valid", bus_valid, 1'b0);
    chk("reset bus_fields", {bus_req, bus_size, bus_addr}, '0);
    chk("reset bus_data_write", bus_data_write, '0);
    chk("reset lsu_flags", {lsu_done, lsu_misalign, lsu_fault, lsu_stall}, '0);
    chk("reset lsu_rdata", lsu_rdata, '0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      run_op(1'b1, vt[i].st, vt[i].f3, vt[i].addr, vt[i].wd, vt[i].rd, vt[i].resp, vt[i].delay, o);
      check_op(vt[i].name, o, 1'b1, vt[i].st, vt[i].f3, vt[i].addr, vt[i].e_mis, vt[i].e_fault,
               1'b1, vt[i].e_rdata, vt[i].e_bdw, vt[i].e_vcnt);
    end

    // Back-to-back: next op presented during DONE is accepted in the following IDLE cycle.
    run_op(1'b1, vt[0].st, vt[0].f3, vt[0].addr, vt[0].wd, vt[0].rd, 0, 0, o);
    check_op("b2b_first", o, 1'b1, vt[0].st, vt[0].f3, vt[0].addr, 0, 0, 1, 64'h1234, 0, 1);
    run_op(1'b0, vt[8].st, vt[8].f3, vt[8].addr, vt[8].wd, vt[8].rd, 0, 1, o);
    check_op("b2b_second", o, 1'b0, vt[8].st, vt[8].f3, vt[8].addr, 0, 0, 1, 0, vt[8].e_bdw, 2);

    // Reset while a request is stuck waiting for ready.
    @(posedge clk); #1;
    lsu_valid = 1'b1; lsu_store = 1'b0; lsu_funct3 = 3'b011; lsu_addr = 32'h8000_0020;
    bus_ready = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid bus_valid_before", bus_valid, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid bus_valid_after", bus_valid, 1'b0);
    chk("rst_mid lsu_done", lsu_done, 1'b0);
    lsu_valid = 1'b0;
    rst = 1'b0;
    run_op(1'b1, vt[2].st, vt[2].f3, vt[2].addr, vt[2].wd, vt[2].rd, 0, 1, o);
    check_op("rst_mid next_op", o, 1'b1, vt[2].st, vt[2].f3, vt[2].addr, 0, 0, 1, vt[2].e_rdata, 0, 2);

    // Randomized ops against the reference model.
    for (int n = 0; n < 60; n++) begin
      bit        st, gap, e_mis, e_fault;
      bit [2:0]  f3;
      bit [31:0] addr;
      bit [63:0] wd, rd, e_rd;
      bit [1:0]  resp;
      int        dly, sz, e_v;
      st = 1'($urandom);
      f3 = 3'($urandom);
      sz = 1 << f3[1:0];
      addr = $urandom;
      if ($urandom_range(3) != 0) addr = addr & ~(32'(sz) - 32'd1);
      wd = {$urandom, $urandom};
      rd = {$urandom, $urandom};
      resp = ($urandom_range(4) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
      dly = $urandom_range(6);
      gap = ($urandom_range(2) != 0);
      e_mis = m_mis(st, f3, addr);
      if (e_mis) begin
        e_v = 0; e_fault = 1'b0; e_rd = '0;
      end else if (dly < TO) begin
        e_v = dly + 1; e_fault = (resp != 2'b00); e_rd = st ? 64'h0 : m_load(f3, addr, rd);
      end else begin
        e_v = TO; e_fault = 1'b1; e_rd = '0;
      end
      run_op(gap, st, f3, addr, wd, rd, resp, dly, o);
      check_op($sformatf("rand%0d", n), o, gap, st, f3, addr, e_mis, e_fault, !e_fault, e_rd,
               m_wlane(f3, addr, wd), e_v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
